counter_ctrl: RTL
=================

# counter_ctrl

User-input front end for `counter_nbit`, sitting directly upstream of it. It synchronises and debounces three push buttons and a data switch bank, and runs a small run/stop/load state machine. It drives the counter's `load`, `en`, `up_down` and `d` inputs, with `en` gated by a programmable prescaler tick so the count advances at a visible rate. All outputs are registered and connect straight to the counter's inputs of the same names.

## Interface
Parameters:
- `N`, default 4: data width; must match the downstream counter width.
- `DEB_CYCLES`, default 4: consecutive stable synchronised samples needed to accept a button level change; must be ≥2.
- `TICK_DIV`, default 5: prescaler period in clk cycles between `en` pulses while running; must be ≥2.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `resetn`  in  1  reset, asynchronous, active-low.
- `btn_run`  in  1  raw run/stop button, asynchronous to clk.
- `btn_load`  in  1  raw load button, asynchronous.
- `btn_dir`  in  1  raw direction button, asynchronous.
- `sw_d`  in  N  raw load-value switches, asynchronous.
- `load`  out  1  one-cycle load strobe to the counter.
- `en`  out  1  one-cycle count-enable pulse.
- `up_down`  out  1  direction level: 0 = up, 1 = down.
- `d`  out  N  load value; stable whenever `load` = 1.

## Operation
- **Synchroniser:** each button passes through a 2-flop synchroniser, giving `s_x`. `sw_d` also passes through 2 flops per bit; switches are not debounced.
- **Debouncer (per button):** holds level `deb_x` and counter `dc_x` (width clog2(DEB_CYCLES)+1).
  - If `s_x` == `deb_x`: `dc_x` <= 0.
  - Else if `dc_x` == DEB_CYCLES-1: `deb_x` <= `s_x` and `dc_x` <= 0.
  - Else: `dc_x`++.
- **Press pulse:** `p_x` = `deb_x` & ~`deb_x_q` (rising edge only). Releases generate nothing.
- **FSM states:** STOP (reset state), RUN, LOAD.
  - STOP: `p_load` → LOAD; else `p_run` → RUN.
  - RUN: `p_load` → LOAD; else `p_run` → STOP.
  - LOAD: unconditionally → STOP after one cycle.
  - A press arriving while in LOAD is dropped.
- **Priority:** when `p_load` and `p_run` occur in the same cycle, load wins and `p_run` is discarded.
- **Direction:** `p_dir` toggles the `up_down` register. This is independent of FSM state, including during LOAD.
- **Prescaler:** `pc` is held at 0 whenever the next state is not RUN. In RUN it counts 0..TICK_DIV-1 and wraps.
- **Registered outputs:**
  - `en` <= 1 for exactly one cycle when in RUN, `pc` == TICK_DIV-1 and no `p_load` that cycle.
  - `load` <= 1 exactly for the cycle the FSM is in LOAD.
  - `d` <= synchronised `sw_d`, captured on the edge entering LOAD and held until the next LOAD.
- **Mutual exclusion:** `load` and `en` are never 1 in the same cycle.

## Timing
- Reset values, applied asynchronously on resetn = 0: `load`=0, `en`=0, `up_down`=0, `d`=0. FSM = STOP, `pc`=0, all sync flops, `deb_x`, `deb_x_q` and `dc_x` = 0.
- Reset mid-operation: outputs drop immediately without waiting for a clock edge. After resetn releases, the block restarts in STOP and ignores any button already held until it is seen rising again. Because the debounced level resets to 0, a held button re-asserts after debounce.
- Button latency: raw button sampled high at edge k and held high. Then:
  - `s_x` = 1 after edge k+1.
  - `deb_x` = 1 after edge k+1+DEB_CYCLES.
  - The FSM/output reaction is registered at edge k+2+DEB_CYCLES. With DEB_CYCLES=4, `load` is high in the cycle after edge k+6.
- Glitch rejection: a synchronised pulse shorter than DEB_CYCLES cycles produces no state change.
- Run rate: the FSM enters RUN at edge r. The first `en` cycle begins at edge r+TICK_DIV, then one `en` every TICK_DIV cycles. Stopping cancels the pending tick and clears `pc`.
- `d` latency: 3 edges from a `sw_d` change to the value available for capture. Switches must be stable ≥3 cycles before the load press is accepted.

## Test plan
- **Reset:** assert resetn=0 mid-cycle with RUN active and `up_down`=1 → `load`, `en`, `up_down` and `d` are all 0 immediately. After release with no buttons pressed: no `en` for 50 cycles.
- **Debounce:** DEB_CYCLES=4. Pulse `btn_run` high 3 cycles → FSM stays STOP and `en` stays 0. Hold it high 10 cycles → RUN. TICK_DIV=5 → `en` high 1 cycle out of every 5, first at RUN entry + 5.
- **Load:** `sw_d`=4'hA stable, press `btn_load` while RUN → `load`=1 for exactly 1 cycle with `d`=4'hA, `en`=0 in that cycle, then FSM = STOP with no further `en`.
- **Direction:** two separate `btn_dir` presses (each held 10 cycles, 10 cycles released) → `up_down` goes 0→1→0, toggling once per press and never on release.
- **Simultaneous:** `btn_run` and `btn_load` rise on the same edge from RUN → a single `load` pulse and final state STOP. Repeat from STOP → STOP again, never RUN.
- **Stop/restart:** stop 2 cycles after an `en`, restart 20 cycles later → the next `en` arrives exactly TICK_DIV cycles after RUN re-entry, with no partial period carried over.

Source files
------------

// File: rtl/counter_ctrl_if.sv
// Button/switch inputs and counter control outputs of counter_ctrl, bundled as one port.
// master = counter_ctrl side, slave = button source / downstream counter side.
interface counter_ctrl_if #(
    parameter int N = 4
);
    logic         btn_run;
    logic         btn_load;
    logic         btn_dir;
    logic [N-1:0] sw_d;
    logic         load;
    logic         en;
    logic         up_down;
    logic [N-1:0] d;

    modport master (
        input  btn_run, btn_load, btn_dir, sw_d,
        output load, en, up_down, d
    );

    modport slave (
        output btn_run, btn_load, btn_dir, sw_d,
        input  load, en, up_down, d
    );
endinterface

// File: rtl/counter_ctrl.sv
// Front end for counter_nbit: synchronises and debounces buttons, runs a run/stop/load
// FSM and drives registered load/en/up_down/d, with en paced by a prescaler tick.
module counter_ctrl #(
    parameter int N          = 4,
    parameter int DEB_CYCLES = 4,
    parameter int TICK_DIV   = 5
) (
    input  logic          clk,
    input  logic          resetn,
    counter_ctrl_if.master bus
);
    localparam int DC_W   = $clog2(DEB_CYCLES) + 1;
    localparam int PC_W   = $clog2(TICK_DIV);
    localparam int B_RUN  = 0;
    localparam int B_LOAD = 1;
    localparam int B_DIR  = 2;

    typedef enum logic [1:0] {S_STOP, S_RUN, S_LOAD} state_t;

    logic [2:0]            btn_raw;
    logic [2:0]            btn_p0;
    logic [2:0]            btn_p1;
    logic [N-1:0]          sw_p0;
    logic [N-1:0]          sw_p1;
    logic [2:0]            deb;
    logic [2:0]            deb_q;
    logic [2:0][DC_W-1:0]  dc;
    logic [2:0]            press;
    state_t                state;
    logic [PC_W-1:0]       pc;
    logic                  nxt_load;
    logic                  nxt_run;
    logic                  load_r;
    logic                  en_r;
    logic                  up_down_r;
    logic [N-1:0]          d_r;

    assign btn_raw = {bus.btn_dir, bus.btn_load, bus.btn_run};

    // Stage p0/p1: two-flop synchronisers for buttons and switches
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            btn_p0 <= '0;
            btn_p1 <= '0;
            sw_p0  <= '0;
            sw_p1  <= '0;
        end else begin
            btn_p0 <= btn_raw;
            btn_p1 <= btn_p0;
            sw_p0  <= bus.sw_d;
            sw_p1  <= sw_p0;
        end
    end

    // Debounce: accept a new level only after DEB_CYCLES consecutive disagreeing samples
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            deb   <= '0;
            deb_q <= '0;
            dc    <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (btn_p1[i] == deb[i]) begin
                    dc[i] <= '0;
                end else if (dc[i] == DC_W'(DEB_CYCLES - 1)) begin
                    deb[i] <= btn_p1[i];
                    dc[i]  <= '0;
                end else begin
                    dc[i] <= dc[i] + 1'b1;
                end
            end
            deb_q <= deb;
        end
    end

    assign press = deb & ~deb_q;

    // Load beats run on the same cycle; presses seen while in LOAD are dropped.
    assign nxt_load = press[B_LOAD] && (state != S_LOAD);
    assign nxt_run  = !press[B_LOAD] &&
                      (((state == S_STOP) && press[B_RUN]) ||
                       ((state == S_RUN) && !press[B_RUN]));

    // FSM, prescaler and registered outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= S_STOP;
            pc        <= '0;
            load_r    <= 1'b0;
            en_r      <= 1'b0;
            up_down_r <= 1'b0;
            d_r       <= '0;
        end else begin
            state <= nxt_load ? S_LOAD : (nxt_run ? S_RUN : S_STOP);

            // Entering RUN starts a fresh period so no partial count carries over a stop
            if (!nxt_run || (state != S_RUN) || (pc == PC_W'(TICK_DIV - 1)))
                pc <= '0;
            else
                pc <= pc + 1'b1;

            en_r      <= (state == S_RUN) && (pc == PC_W'(TICK_DIV - 1)) && !press[B_LOAD];
            load_r    <= nxt_load;
            up_down_r <= up_down_r ^ press[B_DIR];
            if (nxt_load)
                d_r <= sw_p1;
        end
    end

    assign bus.load    = load_r;
    assign bus.en      = en_r;
    assign bus.up_down = up_down_r;
    assign bus.d       = d_r;
endmodule
